adat_rx_sequencer: RTL and testbench
====================================

ADAT_RX_SEQUENCER -- requirements
Module: adat_rx_sequencer

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 4, consecutive good frames needed to lock.
REQ-002 SHALL have parameter HOLD_FRAMES, default 2, consecutive bad frames tolerated while locked.
REQ-003 SHALL have parameter FRAME_CLKS, default 2048, nominal clocks per frame (98.304 MHz / 48 kHz).
REQ-004 SHALL have parameter TOL_CLKS, default 64, allowed frame-interval deviation in clocks.
REQ-005 SHALL have clk  in  1  system clock, 98.304 MHz.
REQ-006 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have in_ready  in  1  one-cycle strobe from the ADAT receiver: new frame present.
REQ-008 SHALL have in_valid  in  1  receiver framing check passed; qualified by in_ready.
REQ-009 SHALL have in_user  in  3  user bits {timecode, midi, smux}; qualified by in_ready.
REQ-010 SHALL have in_audio  in  8x24  signed samples for channels 0-7; qualified by in_ready.
REQ-011 SHALL have out_valid  out  1  sample beat available.
REQ-012 SHALL have out_ready  in  1  downstream accepts beat.
REQ-013 SHALL have out_chan  out  3, out_sample  out  24, out_last  out  1: beat channel, data, channel-7 marker.
REQ-014 SHALL have locked  out  1 (state LOCKED or HOLDOVER), user  out  3 (user bits of last forwarded frame).
REQ-015 SHALL have overrun  out  1 (sticky), err_count  out  16 (saturating bad-frame count), clr_status  in  1.

Function
REQ-016 Interval counter SHALL reset to 0 on each in_ready and increment otherwise, saturating at FRAME_CLKS+TOL_CLKS.
REQ-017 Good frame = in_ready & in_valid & interval within [FRAME_CLKS-TOL_CLKS, FRAME_CLKS+TOL_CLKS]; interval check SHALL be skipped in UNLOCKED.
REQ-018 Bad frame = in_ready with failed check, or counter reaching FRAME_CLKS+TOL_CLKS (timeout; counter then restarts at 0, one bad frame per timeout period).
REQ-019 Lock FSM SHALL have states UNLOCKED, ACQUIRE, LOCKED, HOLDOVER.
REQ-020 UNLOCKED->ACQUIRE on good frame (good_cnt=1); ACQUIRE: good increments, reaching LOCK_FRAMES ->LOCKED, bad ->UNLOCKED.
REQ-021 LOCKED->HOLDOVER on bad frame (bad_cnt=1); HOLDOVER: good ->LOCKED, bad increments, reaching HOLD_FRAMES ->UNLOCKED.
REQ-022 Good frames SHALL be captured into an 8-channel hold buffer only in LOCKED/HOLDOVER and only if buffer free; capture cycle = cycle after in_ready.
REQ-023 The good frame that completes ACQUIRE SHALL be forwarded.
REQ-024 out_valid SHALL assert the cycle after capture; beats ch0..ch7 in order; beat transfers when out_valid & out_ready; out_valid/out_chan/out_sample SHALL hold stable while stalled.
REQ-025 Buffer frees on ch7 transfer; a good frame arriving the same cycle SHALL be accepted (no gap).
REQ-026 Good frame arriving while buffer busy SHALL be dropped and set overrun; buffer contents unaffected.
REQ-027 err_count SHALL increment per bad frame in any state, saturating at 16'hFFFF.
REQ-028 clr_status SHALL clear overrun and err_count next cycle; a simultaneous set event wins.

Reset
REQ-029 On rst: FSM UNLOCKED, counters 0, buffer empty, out_valid=0, out_chan=0, out_sample=0, out_last=0, locked=0, user=0, overrun=0, err_count=0.
REQ-030 Reset mid-frame SHALL abandon partially transferred frame; no further beats emitted.

Configuration
REQ-031 ADAT_SEQ_MUTE_EN defined: on HOLDOVER/LOCKED->UNLOCKED, one 8-beat all-zero frame SHALL be emitted (queued behind any buffered frame).
REQ-032 ADAT_SEQ_MUTE_EN undefined: no beats emitted on loss of lock.

Structure
REQ-033 Package adat_pkg SHALL hold sample_t (signed 24), NUM_CH=8, lock_state_t enum, FRAME_CLKS default.
REQ-034 Interval counter/window check SHALL be sub-module adat_frame_timer.

Verification
REQ-035 4 good frames at 2048-clk spacing, out_ready=1 -> locked on 4th, 8 beats ch0..7 with out_last on ch7.
REQ-036 Locked, out_ready=0 for 20 cycles -> beat ch0 held stable; 2nd frame arriving -> overrun=1, dropped.
REQ-037 Locked, frame at interval 2200 -> HOLDOVER, err_count=1; 2nd bad -> UNLOCKED, locked=0.
REQ-038 Locked, input stops -> bad frame every 2112 clks; UNLOCKED after 2; with ADAT_SEQ_MUTE_EN, 8 zero beats.
REQ-039 rst asserted after beat ch3 -> out_valid=0 next cycle, all outputs reset values.

Source files
------------

// File: rtl/adat_pkg.sv
// Shared types and constants for the ADAT receive sequencer.
// Holds the sample type, channel count, lock-state enum and default frame length.
package adat_pkg;

    localparam int NUM_CH             = 8;
    localparam int CH_W               = $clog2(NUM_CH);
    localparam int SAMPLE_W           = 24;
    localparam int USER_W             = 3;
    localparam int FRAME_CLKS_DEFAULT = 2048;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED,
        HOLDOVER
    } lock_state_t;

endpackage

// File: rtl/adat_frame_timer.sv
// Frame interval timer: measures clocks between in_ready strobes.
// Ports: clk, rst, in_ready in; in_window (interval inside tolerance), timeout out.
module adat_frame_timer #(
    parameter int FRAME_CLKS = 2048,
    parameter int TOL_CLKS   = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic in_ready,
    output logic in_window,
    output logic timeout
);

    localparam int MAX_CLKS = FRAME_CLKS + TOL_CLKS;
    localparam int MIN_CLKS = FRAME_CLKS - TOL_CLKS;
    localparam int CW       = $clog2(MAX_CLKS + 1);

    logic [CW-1:0] cnt_q;
    logic [CW:0]   interval;
    logic          at_limit;

    // interval = clocks elapsed since the previous strobe, counting this one
    assign interval  = {1'b0, cnt_q} + 1'b1;
    assign at_limit  = (interval == (CW+1)'(MAX_CLKS));
    assign in_window = (interval >= (CW+1)'(MIN_CLKS)) &&
                       (interval <= (CW+1)'(MAX_CLKS));
    // a strobe on the limit cycle is a real frame, not a timeout
    assign timeout   = at_limit & ~in_ready;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (in_ready || at_limit)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/adat_rx_sequencer.sv
// ADAT frame lock tracker and 8-channel sample serialiser (optional ADAT_SEQ_MUTE_EN).
// Ports: clk, rst, in_ready/in_valid/in_user/in_audio, out_* beat stream, locked, user, overrun, err_count, clr_status.
module adat_rx_sequencer
    import adat_pkg::*;
#(
    parameter int LOCK_FRAMES = 4,
    parameter int HOLD_FRAMES = 2,
    parameter int FRAME_CLKS  = FRAME_CLKS_DEFAULT,
    parameter int TOL_CLKS    = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_ready,
    input  logic                             in_valid,
    input  logic [USER_W-1:0]                in_user,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0]  in_audio,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [CH_W-1:0]                  out_chan,
    output logic [SAMPLE_W-1:0]              out_sample,
    output logic                             out_last,
    output logic                             locked,
    output logic [USER_W-1:0]                user,
    output logic                             overrun,
    output logic [15:0]                      err_count,
    input  logic                             clr_status
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(HOLD_FRAMES + 1);

    lock_state_t   state_q, state_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic [BW-1:0] bad_cnt_q, bad_cnt_d;
    logic          in_window, timeout;
    logic          good, bad, fwd, lost;

    logic              fwd_q;
    sample_t           stage_q [NUM_CH];
    logic [USER_W-1:0] stage_user_q;
    sample_t           hold_q [NUM_CH];
    logic              full_q;
    logic              mute_pend_q;
    logic              beat_xfer, last_xfer, buf_free;
    logic              load_frame, load_mute, drop;

    adat_frame_timer #(
        .FRAME_CLKS (FRAME_CLKS),
        .TOL_CLKS   (TOL_CLKS)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready),
        .in_window (in_window),
        .timeout   (timeout)
    );

    // interval is meaningless until we have a reference frame
    assign good = in_ready & in_valid & ((state_q == UNLOCKED) | in_window);
    assign bad  = (in_ready & ~good) | timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UNLOCKED;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        fwd        = 1'b0;
        lost       = 1'b0;
        unique case (state_q)
            UNLOCKED: if (good) begin
                if (LOCK_FRAMES <= 1) begin
                    state_d = LOCKED;
                    fwd     = 1'b1;
                end else begin
                    state_d    = ACQUIRE;
                    good_cnt_d = GW'(1);
                end
            end
            ACQUIRE: if (good) begin
                good_cnt_d = good_cnt_q + 1'b1;
                if (good_cnt_d == GW'(LOCK_FRAMES)) begin
                    state_d    = LOCKED;
                    good_cnt_d = '0;
                    fwd        = 1'b1;
                end
            end else if (bad) begin
                state_d    = UNLOCKED;
                good_cnt_d = '0;
            end
            LOCKED: if (good) begin
                fwd = 1'b1;
            end else if (bad) begin
                if (HOLD_FRAMES <= 1) begin
                    state_d = UNLOCKED;
                    lost    = 1'b1;
                end else begin
                    state_d   = HOLDOVER;
                    bad_cnt_d = BW'(1);
                end
            end
            HOLDOVER: if (good) begin
                state_d   = LOCKED;
                bad_cnt_d = '0;
                fwd       = 1'b1;
            end else if (bad) begin
                bad_cnt_d = bad_cnt_q + 1'b1;
                if (bad_cnt_d == BW'(HOLD_FRAMES)) begin
                    state_d   = UNLOCKED;
                    bad_cnt_d = '0;
                    lost      = 1'b1;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    // stage the strobed frame; the buffer decision happens one cycle later
    always_ff @(posedge clk) begin
        if (rst) fwd_q <= 1'b0;
        else     fwd_q <= fwd;
    end

    always_ff @(posedge clk) begin
        if (fwd) begin
            for (int c = 0; c < NUM_CH; c++)
                stage_q[c] <= sample_t'(in_audio[c]);
            stage_user_q <= in_user;
        end
    end

    assign beat_xfer  = out_valid & out_ready;
    assign last_xfer  = beat_xfer & (out_chan == CH_W'(NUM_CH - 1));
    // the ch7 handoff frees the buffer in time for a same-cycle capture
    assign buf_free   = ~full_q | last_xfer;
    assign load_frame = fwd_q & buf_free;
    assign drop       = fwd_q & ~buf_free;
    assign load_mute  = mute_pend_q & buf_free & ~fwd_q;

`ifdef ADAT_SEQ_MUTE_EN
    always_ff @(posedge clk) begin
        if (rst)            mute_pend_q <= 1'b0;
        else if (lost)      mute_pend_q <= 1'b1;
        else if (load_mute) mute_pend_q <= 1'b0;
    end
`else
    logic unused_lost;
    assign mute_pend_q = 1'b0;
    assign unused_lost = lost;
`endif

    always_ff @(posedge clk) begin
        if (load_frame) begin
            hold_q <= stage_q;
        end else if (load_mute) begin
            for (int c = 0; c < NUM_CH; c++)
                hold_q[c] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= 1'b0;
            out_chan <= '0;
            user     <= '0;
        end else begin
            if (load_frame | load_mute) full_q <= 1'b1;
            else if (last_xfer)         full_q <= 1'b0;
            if (beat_xfer)              out_chan <= out_chan + 1'b1;
            if (load_frame)             user <= stage_user_q;
        end
    end

    // a set event in the clear cycle is still recorded
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            err_count <= '0;
        end else begin
            if (drop)            overrun <= 1'b1;
            else if (clr_status) overrun <= 1'b0;
            if (bad) begin
                if (clr_status)            err_count <= 16'd1;
                else if (err_count != '1)  err_count <= err_count + 1'b1;
            end else if (clr_status) begin
                err_count <= '0;
            end
        end
    end

    assign out_valid  = full_q;
    assign out_sample = full_q ? hold_q[out_chan] : '0;
    assign out_last   = full_q & (out_chan == CH_W'(NUM_CH - 1));
    assign locked     = (state_q == LOCKED) | (state_q == HOLDOVER);

endmodule

// File: tb/tb_adat_rx_sequencer.sv
// Directed bench for adat_rx_sequencer: lock, stall/overrun, holdover, timeout, reset.
// Drives and samples on the falling clock edge.
module tb_adat_rx_sequencer;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_ready;
    logic             in_valid;
    logic [2:0]       in_user;
    logic [7:0][23:0] in_audio;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_chan;
    logic [23:0]      out_sample;
    logic             out_last;
    logic             locked;
    logic [2:0]       user;
    logic             overrun;
    logic [15:0]      err_count;
    logic             clr_status;

    int checks = 0;
    int errors = 0;
    int since  = 0;

    always #5 clk = ~clk;

    adat_rx_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_ready   (in_ready),
        .in_valid   (in_valid),
        .in_user    (in_user),
        .in_audio   (in_audio),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_chan   (out_chan),
        .out_sample (out_sample),
        .out_last   (out_last),
        .locked     (locked),
        .user       (user),
        .overrun    (overrun),
        .err_count  (err_count),
        .clr_status (clr_status)
    );

    function automatic logic [23:0] samp(input int k, input int c);
        samp = {8'(k) ^ 8'h80, 8'(c), 8'h3C};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        since++;
    endtask

    task automatic wait_since(input int n);
        while (since < n) tick();
    endtask

    task automatic frame(input logic v, input int k);
        in_ready = 1'b1;
        in_valid = v;
        in_user  = 3'(k);
        for (int c = 0; c < 8; c++) in_audio[c] = samp(k, c);
        since = 0;
        tick();
        in_ready = 1'b0;
        in_valid = 1'b0;
    endtask

    // call at the falling edge where ch0 of frame k is presented
    task automatic drain(input int k, input logic zero);
        for (int c = 0; c < 8; c++) begin
            check("beat_valid", 32'(out_valid), 32'd1);
            check("beat_chan", 32'(out_chan), 32'(c));
            check("beat_sample", 32'(out_sample),
                  zero ? 32'd0 : 32'(samp(k, c)));
            check("beat_last", 32'(out_last), 32'(c == 7));
            tick();
        end
        check("drain_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_ready   = 1'b0;
        in_valid   = 1'b0;
        in_user    = '0;
        in_audio   = '0;
        out_ready  = 1'b1;
        clr_status = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_chan", 32'(out_chan), 32'd0);
        check("rst_sample", 32'(out_sample), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_user", 32'(user), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        rst = 1'b0;

        // acquire lock on the 4th good frame; that frame is forwarded
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) wait_since(2048);
            frame(1'b1, k);
            check("acq_locked", 32'(locked), 32'(k == 4));
            check("acq_no_beat", 32'(out_valid), 32'd0);
        end
        tick();
        drain(4, 1'b0);
        check("user_f4", 32'(user), 32'd4);

        // stall: ch0 held, next frame dropped with overrun
        out_ready = 1'b0;
        wait_since(2048);
        frame(1'b1, 5);
        tick();
        repeat (19) tick();
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_chan", 32'(out_chan), 32'd0);
        check("stall_sample", 32'(out_sample), 32'(samp(5, 0)));
        wait_since(2048);
        frame(1'b1, 6);
        tick();
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_chan", 32'(out_chan), 32'd0);
        check("ovr_sample", 32'(out_sample), 32'(samp(5, 0)));
        out_ready = 1'b1;
        drain(5, 1'b0);
        check("user_f5", 32'(user), 32'd5);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);

        // capture in the same cycle as the ch7 handoff: no gap
        out_ready = 1'b0;
        wait_since(2048);
        frame(1'b1, 7);
        wait_since(2042);
        check("gap_hold_ch0", 32'(out_chan), 32'd0);
        out_ready = 1'b1;
        wait_since(2048);
        frame(1'b1, 8);
        check("gap_ch7", 32'(out_chan), 32'd7);
        check("gap_s7", 32'(out_sample), 32'(samp(7, 7)));
        tick();
        check("gap_ovr", 32'(overrun), 32'd0);
        drain(8, 1'b0);
        check("user_f8", 32'(user), 32'd0);

        // timeout then late frame: HOLDOVER, then UNLOCKED
        wait_since(2112);
        check("to_pre_err", 32'(err_count), 32'd0);
        check("to_pre_lock", 32'(locked), 32'd1);
        tick();
        check("to_err1", 32'(err_count), 32'd1);
        check("to_hold", 32'(locked), 32'd1);
        wait_since(2200);
        frame(1'b1, 9);
        check("late_unlock", 32'(locked), 32'd0);
        check("late_err2", 32'(err_count), 32'd2);
        tick();
`ifdef ADAT_SEQ_MUTE_EN
        drain(0, 1'b1);
`else
        tick();
        check("no_mute1", 32'(out_valid), 32'd0);
`endif
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        check("err_clr", 32'(err_count), 32'd0);

        // relock, then window edges 2112 (good) and 1983 (bad)
        for (int k = 10; k <= 13; k++) begin
            wait_since(2048);
            frame(1'b1, k);
        end
        check("relock", 32'(locked), 32'd1);
        tick();
        drain(13, 1'b0);
        wait_since(2112);
        frame(1'b1, 14);
        check("edge_hi_lock", 32'(locked), 32'd1);
        check("edge_hi_err", 32'(err_count), 32'd0);
        tick();
        drain(14, 1'b0);
        wait_since(1983);
        frame(1'b1, 15);
        check("edge_lo_hold", 32'(locked), 32'd1);
        check("edge_lo_err", 32'(err_count), 32'd1);
        tick();
        check("edge_lo_drop", 32'(out_valid), 32'd0);
        wait_since(1984);
        frame(1'b1, 16);
        check("edge_lo_ok_err", 32'(err_count), 32'd1);
        tick();
        drain(16, 1'b0);

        // input stops: one bad frame per 2112 clocks
        wait_since(2113);
        check("stop_err1", 32'(err_count), 32'd2);
        check("stop_hold", 32'(locked), 32'd1);
        wait_since(4224);
        check("stop_pre2", 32'(err_count), 32'd2);
        tick();
        check("stop_err2", 32'(err_count), 32'd3);
        check("stop_unlock", 32'(locked), 32'd0);
        tick();
`ifdef ADAT_SEQ_MUTE_EN
        drain(0, 1'b1);
`else
        repeat (3) tick();
        check("no_mute2", 32'(out_valid), 32'd0);
`endif

        // relock, reset after ch3 has transferred
        wait_since(4240);
        for (int k = 17; k <= 20; k++) begin
            if (k > 17) wait_since(2048);
            frame(1'b1, k);
        end
        tick();
        repeat (4) tick();
        check("pre_rst_chan", 32'(out_chan), 32'd4);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_chan", 32'(out_chan), 32'd0);
        check("mid_rst_sample", 32'(out_sample), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_user", 32'(user), 32'd0);
        check("mid_rst_err", 32'(err_count), 32'd0);
        rst = 1'b0;
        repeat (10) tick();
        check("post_rst_idle", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
